// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and dispatch; up to 3 in and 3 out per cycle.
// Latency: 1 cycle from accept to visibility; no empty-buffer bypass.
// Backpressure: fetch_stall from registered count only; dispatch pops the leading unstalled run.
package fetch_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
  } IF_ID_PACKET;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  IF_ID_PACKET [2:0]         if_packet_in,
  output logic [2:0]                fetch_stall,
  output IF_ID_PACKET [2:0]         if_id_packet_out,
  input  logic [2:0]                d_stall,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  IF_ID_PACKET   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] free;
  logic [CW-1:0] count_next;
  logic [2:0]    acc;
  logic [1:0]    off [3];
  logic [1:0]    n_acc;
  logic [2:0]    slot_vld;
  logic [2:0]    slot_go;
  logic [1:0]    n_deq;

  // Space is judged on the registered count so same-cycle pops never widen admission.
  assign free = CW'(DEPTH) - count;

  always_comb begin
    fetch_stall = 3'b000;
    acc         = 3'b000;
    for (int i = 0; i < 3; i++) begin
      fetch_stall[i] = (free < CW'(i + 1));
      acc[i]         = if_packet_in[i].valid & ~fetch_stall[i];
    end
  end

  // Accepted slots are compacted onto consecutive tail positions.
  assign off[0] = 2'd0;
  assign off[1] = {1'b0, acc[0]};
  assign off[2] = 2'(acc[0]) + 2'(acc[1]);
  assign n_acc  = 2'(acc[0]) + 2'(acc[1]) + 2'(acc[2]);

  always_comb begin
    if_id_packet_out = '0;
    slot_vld         = 3'b000;
    for (int k = 0; k < 3; k++) begin
      slot_vld[k] = (count > CW'(k));
      if (slot_vld[k]) begin
        if_id_packet_out[k] = mem[head + PW'(k)];
      end
    end
  end

  assign slot_go = slot_vld & ~d_stall;
  assign n_deq   = slot_go[0] ? (slot_go[1] ? (slot_go[2] ? 2'd3 : 2'd2) : 2'd1) : 2'd0;

  assign count_next = count + CW'(n_acc) - CW'(n_deq);

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_deq);
      tail  <= tail + PW'(n_acc);
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !squash) begin
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          mem[tail + PW'(off[i])] <= if_packet_in[i];
        end
      end
    end
  end

endmodule
